// File: rtl/pixie_video_gen.sv
// pixie_video_gen: CDP1861-style raster timing generator with 1-bpp
// framebuffer fetch, display gating and INT/EFx status outputs.
// Optional feature macro: PIXIE_SCANLINE_EN (blank the last replicated line
// of each source row when V_SCALE >= 2).
module pixie_video_gen #(
    parameter int H_TOTAL        = 112,
    parameter int H_ACTIVE_START = 18,
    parameter int H_ACTIVE_BYTES = 8,
    parameter int HSYNC_START    = 2,
    parameter int HSYNC_WIDTH    = 12,
    parameter int V_TOTAL        = 262,
    parameter int V_ACTIVE_START = 64,
    parameter int V_ACTIVE_ROWS  = 32,
    parameter int V_SCALE        = 1,
    parameter int VSYNC_START    = 0,
    parameter int VSYNC_HEIGHT   = 16,
    parameter int ADDR_W         = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_on,
    output logic              fb_read_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              video,
    output logic              HSync,
    output logic              VSync,
    output logic              csync,
    output logic              HBlank,
    output logic              VBlank,
    output logic              video_de,
    output logic              int_req,
    output logic              efx
);
    localparam int HW           = $clog2(H_TOTAL + 1);
    localparam int VW           = $clog2(V_TOTAL + 1);
    localparam int PIX_W        = 8 * H_ACTIVE_BYTES;
    localparam int V_ACTIVE_END = V_ACTIVE_START + V_ACTIVE_ROWS * V_SCALE;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] FETCH_LO = HW'(H_ACTIVE_START - 3);
    localparam logic [HW-1:0] PIX_LO   = HW'(H_ACTIVE_START);
    localparam logic [HW-1:0] PIX_LEN  = HW'(PIX_W);
    localparam logic [HW-1:0] HS_LO    = HW'(HSYNC_START);
    localparam logic [HW-1:0] HS_LEN   = HW'(HSYNC_WIDTH);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VA_LO    = VW'(V_ACTIVE_START);
    localparam logic [VW-1:0] VA_LEN   = VW'(V_ACTIVE_ROWS * V_SCALE);
    localparam logic [VW-1:0] VS_LO    = VW'(VSYNC_START);
    localparam logic [VW-1:0] VS_LEN   = VW'(VSYNC_HEIGHT);
    localparam logic [VW-1:0] INT_LO   = VW'(V_ACTIVE_START - 2);
    localparam logic [VW-1:0] EF_LO    = VW'(V_ACTIVE_START - 4);
    localparam logic [VW-1:0] EF2_LO   = VW'(V_ACTIVE_END - 4);

    localparam logic [2:0]        SUB_LAST = 3'(V_SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE_BYTES);

    // Window tests as wrap-around subtraction, so a zero lower bound needs no special case
    function automatic logic hwin(input logic [HW-1:0] v, input logic [HW-1:0] lo, input logic [HW-1:0] len);
        return (v - lo) < len;
    endfunction

    function automatic logic vwin(input logic [VW-1:0] v, input logic [VW-1:0] lo, input logic [VW-1:0] len);
        return (v - lo) < len;
    endfunction

    logic [HW-1:0]     hc;
    logic [VW-1:0]     vc;
    logic              frame_en;
    logic [2:0]        sub;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col;
    logic              rd_d;
    logic [7:0]        shreg;

    logic          h_wrap, v_wrap, v_act, pix_act, fetch, last_rep;
    logic          hs, vs, hb, vb;
    logic [2:0]    fetch_ph;
    logic [VW-1:0] vc_nxt;

    // Decode the current counters; registered outputs below see these one cycle later
    always_comb begin
        h_wrap   = (hc == H_LAST);
        v_wrap   = (vc == V_LAST);
        vc_nxt   = v_wrap ? '0 : vc + VW'(1);
        v_act    = vwin(vc, VA_LO, VA_LEN);
        pix_act  = v_act && hwin(hc, PIX_LO, PIX_LEN);
        fetch_ph = 3'(hc - FETCH_LO);
        fetch    = frame_en && v_act && hwin(hc, FETCH_LO, PIX_LEN) && (fetch_ph == 3'd0);
        hs       = hwin(hc, HS_LO, HS_LEN);
        vs       = vwin(vc, VS_LO, VS_LEN);
        hb       = !hwin(hc, PIX_LO, PIX_LEN);
        vb       = !v_act;
`ifdef PIXIE_SCANLINE_EN
        last_rep = (V_SCALE >= 2) && (sub == SUB_LAST);
`else
        last_rep = 1'b0;
`endif
    end

    // Raster counters; display enable only changes at the frame wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            hc       <= '0;
            vc       <= '0;
            frame_en <= 1'b0;
        end else begin
            hc <= h_wrap ? '0 : hc + HW'(1);
            if (h_wrap) begin
                vc <= vc_nxt;
                if (v_wrap) frame_en <= disp_on;
            end
        end
    end

    // Source row tracking: sub-line counter plus row base, advanced at each line end
    always_ff @(posedge clk) begin
        if (reset) begin
            sub      <= '0;
            row_base <= '0;
            col      <= '0;
        end else begin
            if (fetch) col <= col + ADDR_W'(1);
            if (h_wrap) begin
                col <= '0;
                if (vc_nxt == VA_LO) begin
                    sub      <= '0;
                    row_base <= '0;
                end else if (v_act) begin
                    if (sub == SUB_LAST) begin
                        sub      <= '0;
                        row_base <= row_base + ROW_STEP;
                    end else begin
                        sub <= sub + 3'd1;
                    end
                end
            end
        end
    end

    // Fetch strobe, pixel shifter and all externally visible registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_read_en <= 1'b0;
            fb_addr    <= '0;
            rd_d       <= 1'b0;
            shreg      <= '0;
            video      <= 1'b0;
            HSync      <= 1'b0;
            VSync      <= 1'b0;
            csync      <= 1'b0;
            HBlank     <= 1'b1;
            VBlank     <= 1'b1;
            video_de   <= 1'b0;
            int_req    <= 1'b0;
            efx        <= 1'b0;
        end else begin
            fb_read_en <= fetch;
            if (fetch) fb_addr <= row_base + col;
            rd_d       <= fb_read_en;
            shreg      <= rd_d ? fb_data : {shreg[6:0], 1'b0};
            video      <= shreg[7] && pix_act && frame_en && !last_rep;
            HSync      <= hs;
            VSync      <= vs;
            csync      <= hs ^ vs;
            HBlank     <= hb;
            VBlank     <= vb;
            video_de   <= !hb && !vb;
            int_req    <= frame_en && (vc >= INT_LO) && (vc < VA_LO);
            efx        <= frame_en && (((vc >= EF_LO) && (vc < VA_LO)) ||
                                       ((vc >= EF2_LO) && v_act));
        end
    end
endmodule

// File: tb/tb_pixie_video_gen.sv
// Scoreboard bench for pixie_video_gen: three instances (defaults with a
// short frame, V_SCALE=2, ADDR_W=6). Expected fetch and pixel events are
// queued ahead of time; a negedge monitor pops and compares them.
module tb_pixie_video_gen;
    localparam int HT  = 112;
    localparam int FR0 = HT * 100;
    localparam int FR1 = HT * 80;
    localparam int FR2 = HT * 100;
    localparam int BIG = 32'h3fffffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, don0, don1;

    logic       rd0, vid0, hs0, vs0, cs0, hb0, vb0, de0, ir0, ef0;
    logic [9:0] addr0;
    logic [7:0] data0;
    logic       rd1, vid1, hs1, vs1, cs1, hb1, vb1, de1, ir1, ef1;
    logic [9:0] addr1;
    logic [7:0] data1;
    logic       rd2, vid2, hs2, vs2, cs2, hb2, vb2, de2, ir2, ef2;
    logic [5:0] addr2;
    logic [7:0] data2;

    pixie_video_gen #(.V_TOTAL(100)) u0 (
        .clk(clk), .reset(rst0), .disp_on(don0), .fb_read_en(rd0), .fb_addr(addr0),
        .fb_data(data0), .video(vid0), .HSync(hs0), .VSync(vs0), .csync(cs0),
        .HBlank(hb0), .VBlank(vb0), .video_de(de0), .int_req(ir0), .efx(ef0));

    pixie_video_gen #(.V_TOTAL(80), .V_SCALE(2), .V_ACTIVE_ROWS(4)) u1 (
        .clk(clk), .reset(rst1), .disp_on(don1), .fb_read_en(rd1), .fb_addr(addr1),
        .fb_data(data1), .video(vid1), .HSync(hs1), .VSync(vs1), .csync(cs1),
        .HBlank(hb1), .VBlank(vb1), .video_de(de1), .int_req(ir1), .efx(ef1));

    pixie_video_gen #(.V_TOTAL(100), .ADDR_W(6), .V_ACTIVE_ROWS(16)) u2 (
        .clk(clk), .reset(rst1), .disp_on(don1), .fb_read_en(rd2), .fb_addr(addr2),
        .fb_data(data2), .video(vid2), .HSync(hs2), .VSync(vs2), .csync(cs2),
        .HBlank(hb2), .VBlank(vb2), .video_de(de2), .int_req(ir2), .efx(ef2));

    // Framebuffer models: byte n holds n, one cycle read latency
    always @(posedge clk) begin
        data0 <= 8'(addr0);
        data1 <= 8'(addr1);
        data2 <= 8'(addr2);
    end

    int g = 0;
    always @(posedge clk) g <= g + 1;

    // Timing model for u0: counters and frame enable, plus last-cycle copies
    int hc_m = 0, vc_m = 0, p_hc = 0, p_vc = 0;
    logic fe_m = 1'b0, p_fe = 1'b0, p_rst = 1'b1;
    always @(posedge clk) begin
        p_hc  <= hc_m;
        p_vc  <= vc_m;
        p_fe  <= fe_m;
        p_rst <= rst0;
        if (rst0) begin
            hc_m <= 0; vc_m <= 0; fe_m <= 1'b0;
        end else begin
            hc_m <= (hc_m == HT - 1) ? 0 : hc_m + 1;
            if (hc_m == HT - 1) begin
                vc_m <= (vc_m == 99) ? 0 : vc_m + 1;
                if (vc_m == 99) fe_m <= don0;
            end
        end
    end

    typedef struct { int g; int a; } ev_t;
    ev_t qf0[$], qv0[$], qf1[$], qf2[$];

    int checks = 0, errors = 0;
    int r1 = -1;
    logic done = 1'b0, fin = 1'b0;

    task automatic add_ev(input int id, input int gg, input int aa);
        ev_t e;
        e.g = gg; e.a = aa;
        case (id)
            0: qf0.push_back(e);
            1: qv0.push_back(e);
            2: qf1.push_back(e);
            default: qf2.push_back(e);
        endcase
    endtask

    function automatic int q_size(input int id);
        case (id)
            0: return qf0.size();
            1: return qv0.size();
            2: return qf1.size();
            default: return qf2.size();
        endcase
    endfunction

    function automatic ev_t q_front(input int id);
        case (id)
            0: return qf0[0];
            1: return qv0[0];
            2: return qf1[0];
            default: return qf2[0];
        endcase
    endfunction

    task automatic q_pop(input int id);
        ev_t e;
        case (id)
            0: e = qf0.pop_front();
            1: e = qv0.pop_front();
            2: e = qf1.pop_front();
            default: e = qf2.pop_front();
        endcase
    endtask

    // Expected u0 fetches and lit pixels for active lines 64..vlast of one frame
    task automatic push_u0(input int fbase, input int vlast, input int cut);
        for (int vc = 64; vc <= vlast; vc++) begin
            int r = vc - 64;
            for (int k = 0; k < 8; k++) begin
                int gg = fbase + vc * HT + 16 + 8 * k;
                if (gg <= cut) add_ev(0, gg, r * 8 + k);
            end
            for (int x = 0; x < 64; x++) begin
                int b  = (r * 8 + x / 8) & 255;
                int gg = fbase + vc * HT + 19 + x;
                if (((b >> (7 - x % 8)) & 1) == 1 && gg <= cut) add_ev(1, gg, 0);
            end
        end
    endtask

    task automatic chk_q(input int id, input logic fire, input int act_a, input logic cmp_a, input string nm);
        ev_t e;
        while (q_size(id) > 0 && q_front(id).g < g) begin
            e = q_front(id);
            checks++; errors++;
            $display("FAIL %s missing: event not seen, required at cycle %0d, now %0d", nm, e.g, g);
            q_pop(id);
        end
        if (fire) begin
            checks++;
            if (q_size(id) > 0 && q_front(id).g == g) begin
                e = q_front(id);
                q_pop(id);
                if (cmp_a && act_a != e.a) begin
                    errors++;
                    $display("FAIL %s addr at cycle %0d: actual %0d required %0d", nm, g, act_a, e.a);
                end
            end else begin
                errors++;
                $display("FAIL %s unexpected event at cycle %0d: actual 1 required 0", nm, g);
            end
        end
    endtask

    logic [7:0] exp_l, act_l;
    logic e_hs, e_vs, e_hb, e_vb, e_ir, e_ef;
    int v1;

    // Monitor: scoreboard pops, per-cycle sync/blank/status check, final summary
    always @(negedge clk) begin
        if (g >= 1 && !fin) begin
            chk_q(0, rd0,  int'(addr0), 1'b1, "fetch0");
            chk_q(1, vid0, 0,           1'b0, "video0");
            chk_q(2, rd1,  int'(addr1), 1'b1, "fetch1");
            chk_q(3, rd2,  int'(addr2), 1'b1, "fetch2");

            act_l = {hs0, vs0, cs0, hb0, vb0, de0, ir0, ef0};
            if (p_rst) begin
                exp_l = 8'b0001_1000;
            end else begin
                e_hs  = (p_hc >= 2) && (p_hc < 14);
                e_vs  = (p_vc < 16);
                e_hb  = !((p_hc >= 18) && (p_hc < 82));
                e_vb  = !((p_vc >= 64) && (p_vc < 96));
                e_ir  = p_fe && (p_vc >= 62) && (p_vc < 64);
                e_ef  = p_fe && (((p_vc >= 60) && (p_vc < 64)) || ((p_vc >= 92) && (p_vc < 96)));
                exp_l = {e_hs, e_vs, e_hs ^ e_vs, e_hb, e_vb, !e_hb && !e_vb, e_ir, e_ef};
            end
            checks++;
            if (act_l !== exp_l) begin
                errors++;
                $display("FAIL lines0 {hs,vs,cs,hb,vb,de,int,efx} at cycle %0d (hc %0d vc %0d): actual %b required %b",
                         g, hc_m, vc_m, act_l, exp_l);
            end

            if (r1 >= 0 && g > r1 && ((g - r1) % HT) == 5) begin
                v1 = ((g - r1) / HT) % 80;
                checks++;
                if (vb1 !== !((v1 >= 64) && (v1 < 72))) begin
                    errors++;
                    $display("FAIL vblank1 line %0d: actual %0b required %0b", v1, vb1, !((v1 >= 64) && (v1 < 72)));
                end
            end

            if (done) begin
                for (int id = 0; id < 4; id++) begin
                    checks++;
                    if (q_size(id) != 0) begin
                        errors++;
                        $display("FAIL leftover queue %0d: actual %0d pending required 0", id, q_size(id));
                    end
                end
                fin = 1'b1;
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    task automatic wait_g(input int t);
        while (g < t) @(negedge clk);
    endtask

    // Stimulus: reset, enable through a wrap, disable a frame, re-enable, reset mid-frame
    initial begin
        int r0, a, r2;
        rst0 = 1'b1; rst1 = 1'b1; don0 = 1'b1; don1 = 1'b1;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        r0 = g;
        r1 = g;
        a  = r0 + 3 * FR0 + 70 * HT + 40;

        push_u0(r0 + FR0, 95, BIG);
        push_u0(r0 + 3 * FR0, 95, a);
        for (int vc = 64; vc < 72; vc++)
            for (int k = 0; k < 8; k++)
                add_ev(2, r0 + FR1 + vc * HT + 16 + 8 * k, ((vc - 64) / 2) * 8 + k);
        for (int vc = 64; vc < 80; vc++)
            for (int k = 0; k < 8; k++)
                add_ev(3, r0 + FR2 + vc * HT + 16 + 8 * k, ((vc - 64) * 8 + k) % 64);

        wait_g(r0 + FR0 + 5);
        don0 = 1'b0; don1 = 1'b0;
        wait_g(r0 + 2 * FR0 + 100);
        don0 = 1'b1;

        wait_g(a);
        rst0 = 1'b1;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        r2 = g;
        push_u0(r2 + FR0, 65, BIG);

        wait_g(r2 + FR0 + 66 * HT);
        done = 1'b1;
    end
endmodule
